// File: rtl/time_cnt_sync.sv
// rtl/time_cnt_sync.sv - ultrasound period / modulation index counters phase-locked to SYS_TIME
// Optional TIME_CNT_DRIFT_CHECK_EN: shadow-time monitor with DRIFT_ERR pulse and auto-resync.
module time_cnt_sync #(
  parameter int ULTRASOUND_CNT_CYCLE = 510,
  parameter int CNT_WIDTH            = 9,
  parameter int MOD_WIDTH            = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 LOCKED,
  input  logic [63:0]          SYS_TIME,
  input  logic                 SYNC,
  input  logic [MOD_WIDTH-1:0] MOD_CYCLE,
  input  logic [MOD_WIDTH-1:0] MOD_DIV,
  output logic [CNT_WIDTH-1:0] TIME_CNT,
  output logic                 CYCLE_START,
  output logic [MOD_WIDTH-1:0] MOD_IDX,
  output logic                 SYNCED,
`ifdef TIME_CNT_DRIFT_CHECK_EN
  output logic                 DRIFT_ERR,
`endif
  output logic                 BUSY
);

  localparam int SYNC_LATENCY = 194;
  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(ULTRASOUND_CNT_CYCLE - 1);
  localparam logic [6:0] LAST_ITER = 7'd63;
  localparam logic [6:0] LOAD_ITER = 7'd64;

  typedef enum logic [2:0] {WAIT_LOCK, IDLE, DIV_T, DIV_Q, DIV_M, RUN} state_t;

  state_t               state_q, state_d;
  logic [6:0]           iter_q, iter_d;
  logic [63:0]          dvd_q, dvd_d;
  logic [63:0]          rem_q, rem_d;
  logic [63:0]          divisor_q, divisor_d;
  logic [MOD_WIDTH-1:0] mod_div_q, mod_div_d;
  logic [MOD_WIDTH-1:0] mod_cycle_q, mod_cycle_d;
  logic [CNT_WIDTH-1:0] r1_q, r1_d;
  logic [MOD_WIDTH-1:0] r2_q, r2_d;
  logic [MOD_WIDTH-1:0] r3_q, r3_d;
  logic [CNT_WIDTH-1:0] time_cnt_q, time_cnt_d;
  logic [MOD_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [MOD_WIDTH-1:0] mod_idx_q, mod_idx_d;
  logic                 synced_q, synced_d;
  logic                 resync;
  logic                 drift;

  // Restoring divider step: one quotient bit per cycle, quotient shifts into the dividend register.
  logic [64:0] rem_sh;
  logic        ge;
  logic [63:0] rem_nx;
  logic [63:0] quo_nx;

  assign rem_sh = {rem_q, dvd_q[63]};
  assign ge     = rem_sh[64] | (rem_sh[63:0] >= divisor_q);
  assign rem_nx = ge ? (rem_sh[63:0] - divisor_q) : rem_sh[63:0];
  assign quo_nx = {dvd_q[62:0], ge};

`ifdef TIME_CNT_DRIFT_CHECK_EN
  logic [63:0] t_q, t_d;
  logic [63:0] shadow_q, shadow_d;
  logic        drift_err_q, drift_err_d;

  assign drift     = (state_q == RUN) && (shadow_q != SYS_TIME);
  assign DRIFT_ERR = drift_err_q;
`else
  assign drift = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= WAIT_LOCK;
      iter_q      <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      mod_div_q   <= '0;
      mod_cycle_q <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      time_cnt_q  <= '0;
      div_cnt_q   <= '0;
      mod_idx_q   <= '0;
      synced_q    <= 1'b0;
`ifdef TIME_CNT_DRIFT_CHECK_EN
      t_q         <= '0;
      shadow_q    <= '0;
      drift_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      mod_div_q   <= mod_div_d;
      mod_cycle_q <= mod_cycle_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      time_cnt_q  <= time_cnt_d;
      div_cnt_q   <= div_cnt_d;
      mod_idx_q   <= mod_idx_d;
      synced_q    <= synced_d;
`ifdef TIME_CNT_DRIFT_CHECK_EN
      t_q         <= t_d;
      shadow_q    <= shadow_d;
      drift_err_q <= drift_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    mod_div_d   = mod_div_q;
    mod_cycle_d = mod_cycle_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    time_cnt_d  = time_cnt_q;
    div_cnt_d   = div_cnt_q;
    mod_idx_d   = mod_idx_q;
    synced_d    = synced_q;
    resync      = 1'b0;
`ifdef TIME_CNT_DRIFT_CHECK_EN
    t_d         = t_q;
    shadow_d    = shadow_q;
    drift_err_d = 1'b0;
`endif

    case (state_q)
      WAIT_LOCK: state_d = IDLE;
      IDLE:      resync  = SYNC;
      DIV_T, DIV_Q, DIV_M: begin
        if (iter_q == LOAD_ITER) begin
          // Results describe time T, which is exactly SYS_TIME in the first RUN cycle.
          state_d    = RUN;
          time_cnt_d = r1_q;
          div_cnt_d  = r2_q;
          mod_idx_d  = r3_q;
          synced_d   = 1'b1;
`ifdef TIME_CNT_DRIFT_CHECK_EN
          shadow_d   = t_q;
`endif
        end else begin
          iter_d = iter_q + 7'd1;
          dvd_d  = quo_nx;
          rem_d  = rem_nx;
          if (iter_q == LAST_ITER) begin
            rem_d = '0;
            if (state_q == DIV_T) begin
              r1_d      = rem_nx[CNT_WIDTH-1:0];
              divisor_d = 64'(mod_div_q);
              iter_d    = '0;
              state_d   = DIV_Q;
            end else if (state_q == DIV_Q) begin
              r2_d      = rem_nx[MOD_WIDTH-1:0];
              divisor_d = 64'(mod_cycle_q);
              iter_d    = '0;
              state_d   = DIV_M;
            end else begin
              r3_d = rem_nx[MOD_WIDTH-1:0];
            end
          end
        end
      end
      RUN: begin
        if (time_cnt_q == C_LAST) begin
          time_cnt_d = '0;
          if (div_cnt_q == mod_div_q - MOD_WIDTH'(1)) begin
            div_cnt_d = '0;
            mod_idx_d = (mod_idx_q == mod_cycle_q - MOD_WIDTH'(1)) ? '0 : mod_idx_q + MOD_WIDTH'(1);
          end else begin
            div_cnt_d = div_cnt_q + MOD_WIDTH'(1);
          end
        end else begin
          time_cnt_d = time_cnt_q + CNT_WIDTH'(1);
        end
`ifdef TIME_CNT_DRIFT_CHECK_EN
        shadow_d    = shadow_q + 64'd1;
        drift_err_d = drift;
`endif
        resync = SYNC | drift;
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (resync) begin
      state_d     = DIV_T;
      iter_d      = '0;
      rem_d       = '0;
      dvd_d       = SYS_TIME + 64'(SYNC_LATENCY);
      divisor_d   = 64'(ULTRASOUND_CNT_CYCLE);
      mod_div_d   = (MOD_DIV == '0) ? MOD_WIDTH'(1) : MOD_DIV;
      mod_cycle_d = (MOD_CYCLE == '0) ? MOD_WIDTH'(1) : MOD_CYCLE;
      time_cnt_d  = '0;
      div_cnt_d   = '0;
      mod_idx_d   = '0;
      synced_d    = 1'b0;
`ifdef TIME_CNT_DRIFT_CHECK_EN
      t_d         = SYS_TIME + 64'(SYNC_LATENCY);
`endif
    end

    if (!LOCKED) begin
      state_d    = WAIT_LOCK;
      time_cnt_d = '0;
      div_cnt_d  = '0;
      mod_idx_d  = '0;
      synced_d   = 1'b0;
`ifdef TIME_CNT_DRIFT_CHECK_EN
      drift_err_d = 1'b0;
`endif
    end
  end

  assign TIME_CNT    = time_cnt_q;
  assign MOD_IDX     = mod_idx_q;
  assign SYNCED      = synced_q;
  assign CYCLE_START = synced_q && (time_cnt_q == '0);
  assign BUSY        = (state_q == DIV_T) || (state_q == DIV_Q) || (state_q == DIV_M);

endmodule

// File: tb/tb_time_cnt_sync.sv
// tb/tb_time_cnt_sync.sv - randomized bench for time_cnt_sync against an arithmetic time model
module tb_time_cnt_sync;

  localparam int C   = 510;
  localparam int LAT = 194;
  localparam int S_WAIT = 0, S_IDLE = 1, S_BUSY = 2, S_RUN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        sync = 1'b0;
  logic [63:0] sys_time = 64'd0;
  logic [15:0] mod_cycle = 16'd10;
  logic [15:0] mod_div = 16'd4;
  logic [8:0]  time_cnt;
  logic        cycle_start;
  logic [15:0] mod_idx;
  logic        synced;
  logic        busy;
`ifdef TIME_CNT_DRIFT_CHECK_EN
  logic        drift_err;
`endif

  logic        load_req = 1'b0;
  logic [63:0] load_val = 64'd0;
  logic        skip_req = 1'b0;

  int          checks = 0;
  int          errors = 0;

  // Model: state, latched time anchor and divisors, cycles elapsed since RUN entry.
  int          m_state = S_WAIT;
  int          m_cnt = 0;
  logic [63:0] m_anchor = 64'd0;
  logic [63:0] m_k = 64'd0;
  logic [71:0] m_d = 72'd1;
  logic [71:0] m_m = 72'd1;
  logic        m_drift = 1'b0;
  logic        drift_now;
  logic [71:0] u;
  logic [63:0] e_tc, e_mi;
  logic        run;

  time_cnt_sync dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .LOCKED      (locked),
    .SYS_TIME    (sys_time),
    .SYNC        (sync),
    .MOD_CYCLE   (mod_cycle),
    .MOD_DIV     (mod_div),
    .TIME_CNT    (time_cnt),
    .CYCLE_START (cycle_start),
    .MOD_IDX     (mod_idx),
    .SYNCED      (synced),
`ifdef TIME_CNT_DRIFT_CHECK_EN
    .DRIFT_ERR   (drift_err),
`endif
    .BUSY        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at sys_time=%0d: got %0d expected %0d", tag, sys_time, got, exp);
    end
  endtask

  always begin
    @(posedge clk);
    drift_now = 1'b0;
`ifdef TIME_CNT_DRIFT_CHECK_EN
    drift_now = (m_state == S_RUN) && (sys_time != m_anchor + m_k);
`endif
    m_drift = 1'b0;
    if (!rst_n || !locked) begin
      m_state = S_WAIT;
    end else if (m_state == S_WAIT) begin
      m_state = S_IDLE;
    end else if ((m_state == S_IDLE && sync) || (m_state == S_RUN && (sync || drift_now))) begin
      m_state  = S_BUSY;
      m_cnt    = 1;
      m_anchor = sys_time + 64'(LAT);
      m_d      = (mod_div == 16'd0) ? 72'd1 : 72'(mod_div);
      m_m      = (mod_cycle == 16'd0) ? 72'd1 : 72'(mod_cycle);
      m_drift  = drift_now;
    end else if (m_state == S_BUSY) begin
      if (m_cnt == LAT - 1) begin
        m_state = S_RUN;
        m_k     = 64'd0;
      end else begin
        m_cnt++;
      end
    end else if (m_state == S_RUN) begin
      m_k = m_k + 64'd1;
    end
    sys_time <= load_req ? load_val : (skip_req ? sys_time : sys_time + 64'd1);
  end

  // Expected outputs for absolute time u = anchor + elapsed, computed without 64-bit wrap.
  always begin
    @(negedge clk);
    run  = (m_state == S_RUN);
    u    = {8'd0, m_anchor} + {8'd0, m_k};
    e_tc = run ? 64'(u % 72'(C)) : 64'd0;
    e_mi = run ? 64'(((u / 72'(C)) / m_d) % m_m) : 64'd0;
    check_eq("synced", 64'(synced), 64'(run));
    check_eq("busy", 64'(busy), 64'(m_state == S_BUSY));
    check_eq("time_cnt", 64'(time_cnt), e_tc);
    check_eq("mod_idx", 64'(mod_idx), e_mi);
    check_eq("cycle_start", 64'(cycle_start), 64'(run && e_tc == 64'd0));
`ifdef TIME_CNT_DRIFT_CHECK_EN
    check_eq("drift_err", 64'(drift_err), 64'(m_drift));
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_at(input logic [63:0] t);
    @(negedge clk);
    load_req = 1'b1;
    load_val = t;
    @(negedge clk);
    load_req = 1'b0;
    sync     = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic relock();
    locked = 1'b0;
    cyc(3);
    locked = 1'b1;
    cyc(3);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      sync = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) begin
        mod_div   = 16'($urandom_range(0, 7));
        mod_cycle = 16'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    sync = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic found;
    cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sync = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sync   = 1'b0;
    locked = 1'b1;
    cyc(3);

    // Basic sync at 1000, with a stray SYNC inside DIV_Q
    mod_div   = 16'd4;
    mod_cycle = 16'd10;
    sync_at(64'd1000);
    busy_cnt = 0;
    for (int i = 0; i < 400 && !synced; i++) begin
      if (busy) busy_cnt++;
      sync = (i == 100);
      @(negedge clk);
    end
    sync = 1'b0;
    check_eq("busy_len", 64'(busy_cnt), 64'd193);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (sys_time == 64'd1194) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("reach_1194", 64'(found), 64'd1);
    check_eq("tc_at_1194", 64'(time_cnt), 64'd174);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (sys_time == 64'd1530) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("reach_1530", 64'(found), 64'd1);
    check_eq("cs_at_1530", 64'(cycle_start), 64'd1);
    cyc(500);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    cyc(600);

    // Modulation stepping
    mod_div   = 16'd3;
    mod_cycle = 16'd5;
    relock();
    sync_at(64'd1 << 40);
    cyc(20000);

    // Zero divisors and 64-bit wrap
    mod_div   = 16'd0;
    mod_cycle = 16'd0;
    relock();
    sync_at(64'($urandom));
    cyc(1500);
    mod_div   = 16'($urandom_range(0, 4));
    mod_cycle = 16'($urandom_range(0, 6));
    relock();
    sync_at(64'hFFFF_FFFF_FFFF_FFFF - 64'd99);
    cyc(400);
    relock();
    sync_at(64'hFFFF_FFFF_FFFF_FFFF - 64'd699);
    run_random(1200);

    for (int it = 0; it < 6; it++) begin
      mod_div   = 16'($urandom_range(0, 5));
      mod_cycle = 16'($urandom_range(0, 7));
      relock();
      sync_at({$urandom, $urandom});
      run_random(600 + $urandom_range(0, 600));
    end

`ifdef TIME_CNT_DRIFT_CHECK_EN
    mod_div   = 16'd2;
    mod_cycle = 16'd3;
    relock();
    sync_at(64'd5000);
    cyc(300);
    skip_req = 1'b1;
    @(negedge clk);
    skip_req = 1'b0;
    cyc(450);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
